// File: rtl/btn_evt_pkg.sv
// Shared definitions for the button event controller: event codes and the
// per-button state encoding.
package btn_evt_pkg;

  // Event codes carried in evt_data[top:top-1]
  localparam logic [1:0] EVT_PRESS     = 2'b00;
  localparam logic [1:0] EVT_SHORT_REL = 2'b01;
  localparam logic [1:0] EVT_LONG      = 2'b10;
  localparam logic [1:0] EVT_LONG_REL  = 2'b11;

  // Per-button classification state
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HELD = 2'b01,
    ST_LONG = 2'b10
  } btn_state_e;

endpackage

// File: rtl/btn_evt_fsm.sv
// One button's classifier: edge detect, hold-time counter in ms ticks,
// press/short/long state machine and a single-entry pending event slot.
module btn_evt_fsm
  import btn_evt_pkg::*;
#(
  parameter int LONG_MS = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db_i,
  input  logic       enable_i,
  input  logic       tick_i,
  input  logic       clr_i,
  output logic       slot_valid_o,
  output logic [1:0] slot_code_o,
  output logic       held_o,
  output logic       drop_o
);

  localparam int             MSW       = $clog2(LONG_MS + 1);
  localparam logic [MSW-1:0] LONG_LAST = MSW'(LONG_MS - 1);
  localparam logic [MSW-1:0] LONG_FULL = MSW'(LONG_MS);

  btn_state_e     state_q;
  logic [MSW-1:0] ms_q;
  logic           prev_q;
  logic           held_q;
  logic           slot_v_q;
  logic [1:0]     slot_c_q;

  logic       rise_s;
  logic       fall_s;
  logic       emit_s;
  logic [1:0] emit_code_s;

  // Edges only count while enabled; prev_q always tracks the input.
  assign rise_s = enable_i & db_i & ~prev_q;
  assign fall_s = enable_i & ~db_i & prev_q;

  // Decide which event (if any) this button raises this cycle; a release
  // takes priority over the long-press threshold landing in the same cycle.
  always_comb begin
    emit_s      = 1'b0;
    emit_code_s = EVT_PRESS;
    case (state_q)
      ST_IDLE: begin
        if (rise_s) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_PRESS;
        end else begin
          emit_s      = 1'b0;
        end
      end
      ST_HELD: begin
        if (fall_s) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_SHORT_REL;
        end else if (enable_i && tick_i && (ms_q == LONG_LAST)) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_LONG;
        end else begin
          emit_s      = 1'b0;
        end
      end
      ST_LONG: begin
        if (fall_s) begin
          emit_s      = 1'b1;
          emit_code_s = EVT_LONG_REL;
        end else begin
          emit_s      = 1'b0;
        end
      end
      default: begin
        emit_s      = 1'b0;
        emit_code_s = EVT_PRESS;
      end
    endcase
  end

  // A slot being drained by the arbiter this cycle can take the new event.
  assign drop_o = emit_s & slot_v_q & ~clr_i;

  // State, hold counter, held flag and pending slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ms_q     <= '0;
      prev_q   <= 1'b0;
      held_q   <= 1'b0;
      slot_v_q <= 1'b0;
      slot_c_q <= 2'b00;
    end else begin
      prev_q <= db_i;
      case (state_q)
        ST_IDLE: begin
          if (rise_s) begin
            state_q <= ST_HELD;
            ms_q    <= '0;
          end
        end
        ST_HELD: begin
          if (fall_s) begin
            state_q <= ST_IDLE;
          end else if (enable_i && tick_i) begin
            if (ms_q == LONG_LAST) begin
              ms_q    <= LONG_FULL;
              held_q  <= 1'b1;
              state_q <= ST_LONG;
            end else begin
              ms_q <= ms_q + MSW'(1);
            end
          end
        end
        ST_LONG: begin
          if (fall_s) begin
            held_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          held_q  <= 1'b0;
        end
      endcase
      if (emit_s && (!slot_v_q || clr_i)) begin
        slot_v_q <= 1'b1;
        slot_c_q <= emit_code_s;
      end else if (clr_i) begin
        slot_v_q <= 1'b0;
      end
    end
  end

  assign slot_valid_o = slot_v_q;
  assign slot_code_o  = slot_c_q;
  assign held_o       = held_q;

endmodule

// File: rtl/button_event_ctrl.sv
// Button event controller: ms tick prescaler, per-button classifiers,
// round-robin arbitration of pending events into a FWFT event FIFO.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter  int NUM_BTN    = 4,
  parameter  int CLK_DIV    = 38000,
  parameter  int LONG_MS    = 1000,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDXW       = $clog2(NUM_BTN)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_BTN-1:0]  db_in,
  input  logic                enable,
  output logic                evt_valid,
  output logic [IDXW+1:0]     evt_data,
  input  logic                evt_ready,
  output logic                overflow,
  input  logic                ovf_clear,
  output logic [NUM_BTN-1:0]  btn_held
);

  localparam int              TCW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TCW-1:0]  TC_LAST = TCW'(CLK_DIV - 1);
  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]     DEPTH_W = (PW+1)'(FIFO_DEPTH);
  localparam logic [IDXW:0]   NB_W    = (IDXW+1)'(NUM_BTN);
  localparam logic [IDXW-1:0] NB_LAST = IDXW'(NUM_BTN - 1);
  localparam int              EW      = IDXW + 2;

  logic [TCW-1:0]  tick_cnt_q;
  logic            armed_q;
  logic [IDXW-1:0] rr_q;
  logic            overflow_q;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q;
  logic [PW-1:0]   rd_q;
  logic [PW:0]     count_q;
  logic [PW:0]     count_d;

  logic               tick_s;
  logic               fsm_en_s;
  logic [NUM_BTN-1:0] slot_valid_s;
  logic [1:0]         slot_code_s [NUM_BTN];
  logic [NUM_BTN-1:0] drop_s;
  logic [NUM_BTN-1:0] clr_s;
  logic               pop_s;
  logic               can_push_s;
  logic               push_s;
  logic               found_s;
  logic [IDXW-1:0]    pick_s;
  logic [IDXW:0]      cand_s;
  logic [EW-1:0]      push_data_s;

  assign tick_s = (tick_cnt_q == TC_LAST);

  // Free-running ms prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else if (tick_s) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TCW'(1);
    end
  end

  // Edge detection is held off for the first cycle out of reset: prev levels
  // restart at 0, and a button still down must not look like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q <= 1'b0;
    end else begin
      armed_q <= 1'b1;
    end
  end

  assign fsm_en_s = enable & armed_q;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_evt_fsm #(
      .LONG_MS (LONG_MS)
    ) u_fsm (
      .clk          (clk),
      .reset        (reset),
      .db_i         (db_in[g]),
      .enable_i     (fsm_en_s),
      .tick_i       (tick_s),
      .clr_i        (clr_s[g]),
      .slot_valid_o (slot_valid_s[g]),
      .slot_code_o  (slot_code_s[g]),
      .held_o       (btn_held[g]),
      .drop_o       (drop_s[g])
    );
  end

  assign pop_s      = evt_valid & evt_ready;
  assign can_push_s = (count_q != DEPTH_W) | pop_s;

  // Round-robin search: first pending slot at or after rr_q, wrapping.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    cand_s  = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      cand_s = {1'b0, rr_q} + (IDXW+1)'(i);
      if (cand_s >= NB_W) begin
        cand_s = cand_s - NB_W;
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && slot_valid_s[cand_s[IDXW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = cand_s[IDXW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  assign push_s      = found_s & can_push_s;
  assign clr_s       = push_s ? ({{(NUM_BTN-1){1'b0}}, 1'b1} << pick_s) : '0;
  assign push_data_s = {slot_code_s[pick_s], pick_s};

  // Next FIFO occupancy from push/pop.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Round-robin pointer moves just past the slot that was granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else if (push_s) begin
      rr_q <= (pick_s == NB_LAST) ? '0 : pick_s + IDXW'(1);
    end
  end

  // Event FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_s) begin
        mem_q[wr_q] <= push_data_s;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop_s) begin
        rd_q <= rd_q + PW'(1);
      end
      count_q <= count_d;
    end
  end

  // Sticky overflow; a drop in the clear cycle keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (|drop_s) begin
      overflow_q <= 1'b1;
    end else if (ovf_clear) begin
      overflow_q <= 1'b0;
    end
  end

  assign evt_valid = (count_q != '0);
  assign evt_data  = evt_valid ? mem_q[rd_q] : '0;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Randomised and directed bench for button_event_ctrl against a cycle-level
// behavioural model (queue-based FIFO, integer hold timers).
module tb_button_event_ctrl;

  localparam int NB = 4;
  localparam int CD = 5;
  localparam int LM = 8;
  localparam int FD = 4;
  localparam int IW = 2;
  localparam int EW = IW + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] db_in;
  logic          enable;
  logic          evt_valid;
  logic [EW-1:0] evt_data;
  logic          evt_ready;
  logic          overflow;
  logic          ovf_clear;
  logic [NB-1:0] btn_held;

  always #5 clk = ~clk;

  button_event_ctrl #(
    .NUM_BTN    (NB),
    .CLK_DIV    (CD),
    .LONG_MS    (LM),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .db_in     (db_in),
    .enable    (enable),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .overflow  (overflow),
    .ovf_clear (ovf_clear),
    .btn_held  (btn_held)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: 0 = released, 1 = pressed (short so far), 2 = long
  int            m_mode  [NB];
  int            m_ticks [NB];
  bit            m_prev  [NB];
  bit            m_pend  [NB];
  logic [1:0]    m_code  [NB];
  logic [EW-1:0] m_q [$];
  int            m_rr;
  int            m_tcnt;
  bit            m_ovf;
  bit            m_armed;

  task automatic model_step();
    bit tick, pop, room, drop, en, cur, rise, fall;
    int pick, b, ev;
    if (reset) begin
      for (int i = 0; i < NB; i++) begin
        m_mode[i] = 0; m_ticks[i] = 0; m_prev[i] = 1'b0; m_pend[i] = 1'b0; m_code[i] = 2'b00;
      end
      m_q.delete();
      m_rr = 0; m_tcnt = 0; m_ovf = 1'b0; m_armed = 1'b0;
      return;
    end
    tick = (m_tcnt == CD - 1);
    pop  = (m_q.size() > 0) && evt_ready;
    room = (m_q.size() < FD) || pop;
    pick = -1;
    if (room) begin
      for (int k = 0; k < NB; k++) begin
        b = (m_rr + k) % NB;
        if (pick < 0 && m_pend[b]) pick = b;
      end
    end
    if (pop) void'(m_q.pop_front());
    if (pick >= 0) begin
      m_q.push_back({m_code[pick], IW'(pick)});
      m_pend[pick] = 1'b0;
      m_rr = (pick + 1) % NB;
    end
    drop = 1'b0;
    en   = enable && m_armed;
    for (int i = 0; i < NB; i++) begin
      cur  = db_in[i];
      rise = en && cur && !m_prev[i];
      fall = en && !cur && m_prev[i];
      ev   = -1;
      if (m_mode[i] == 0) begin
        if (rise) begin ev = 0; m_mode[i] = 1; m_ticks[i] = 0; end
      end else if (m_mode[i] == 1) begin
        if (fall) begin
          ev = 1; m_mode[i] = 0;
        end else if (en && tick) begin
          m_ticks[i]++;
          if (m_ticks[i] == LM) begin ev = 2; m_mode[i] = 2; end
        end
      end else begin
        if (fall) begin ev = 3; m_mode[i] = 0; end
      end
      if (ev >= 0) begin
        if (m_pend[i]) drop = 1'b1;
        else begin m_pend[i] = 1'b1; m_code[i] = 2'(ev); end
      end
      m_prev[i] = cur;
    end
    if (drop) m_ovf = 1'b1;
    else if (ovf_clear) m_ovf = 1'b0;
    m_tcnt  = tick ? 0 : m_tcnt + 1;
    m_armed = 1'b1;
  endtask

  task automatic cycle();
    logic [NB-1:0] exp_held;
    model_step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NB; i++) exp_held[i] = (m_mode[i] == 2);
    check_val("evt_valid", evt_valid, (m_q.size() > 0));
    if (m_q.size() > 0) check_val("evt_data", evt_data, m_q[0]);
    check_val("overflow", overflow, m_ovf);
    check_val("btn_held", btn_held, exp_held);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; evt_ready = 1'b1; ovf_clear = 1'b0; db_in = '0;
    run(3);
    check_val("rst_data", evt_data, 0);
    reset = 1'b0;

    // short press on btn0
    db_in = 4'b0001; run(CD * 4);
    db_in = 4'b0000; run(10);

    // long press on btn2
    db_in = 4'b0100; run(CD * (LM + 4));
    check_val("long_held2", btn_held[2], 1);
    db_in = 4'b0000; run(10);
    check_val("long_rel_held2", btn_held[2], 0);

    // simultaneous bursts, twice
    db_in = 4'b1111; run(8);
    db_in = 4'b0000; run(8);
    db_in = 4'b1111; run(8);
    db_in = 4'b0000; run(8);

    // overflow: fill FIFO, btn1 release fills its slot, re-press is dropped
    evt_ready = 1'b0;
    db_in = 4'b1111; run(8);
    db_in = 4'b1101; run(2);
    db_in = 4'b1111; run(2);
    check_val("ovf_set", overflow, 1);
    ovf_clear = 1'b1; run(1);
    ovf_clear = 1'b0;
    check_val("ovf_clr", overflow, 0);
    evt_ready = 1'b1; run(8);
    db_in = 4'b0000; run(12);

    // release exactly on the cycle the hold count reaches LONG_MS
    evt_ready = 1'b0;
    db_in = 4'b1000;
    for (int k = 0; k < 200; k++) begin
      if (m_mode[3] == 1 && m_ticks[3] == LM - 1 && m_tcnt == CD - 1) begin
        db_in[3] = 1'b0;
        cycle();
        break;
      end
      cycle();
    end
    run(3);
    check_val("bnd_press", evt_data, {2'b00, 2'd3});
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    check_val("bnd_short", evt_data, {2'b01, 2'd3});
    evt_ready = 1'b1; run(4);
    check_val("bnd_nolong", evt_valid, 0);
    check_val("bnd_held3", btn_held[3], 0);

    // reset in the middle of a hold, button kept down
    db_in = 4'b0010; run(CD * 4);
    reset = 1'b1; run(1); reset = 1'b0;
    check_val("rst_mid_valid", evt_valid, 0);
    run(CD * LM + 10);
    check_val("rst_mid_nopress", evt_valid, 0);
    check_val("rst_mid_held", btn_held, 0);
    evt_ready = 1'b0;
    db_in = 4'b0000; run(2);
    db_in = 4'b0010; run(3);
    check_val("rst_mid_repress", evt_data, {2'b00, 2'd1});
    evt_ready = 1'b1; db_in = 4'b0000; run(6);

    // random traffic
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < NB; b++) if ($urandom_range(0, 24) == 0) db_in[b] = ~db_in[b];
      evt_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 15) != 0);
      ovf_clear = ($urandom_range(0, 31) == 0);
      reset     = ($urandom_range(0, 599) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
